// File: rtl/scalar_lsu_pkg.sv
// Shared types for the scalar load/store unit: access sizes, response-FIFO entry, pending-load record
// and the byte-lane mask helper.
package scalar_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } lsu_size_e;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
    } rsp_entry_t;

    typedef struct packed {
        logic [1:0] offset;
        lsu_size_e  size;
        logic       sext;
        logic [4:0] tag;
    } pend_t;

    // Reserved size falls through to a full-word mask.
    function automatic logic [3:0] lane_mask(input lsu_size_e size, input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << offset;
            SIZE_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/scalar_lsu_rsp_fifo.sv
// Load-response FIFO. Two push ports written in order (port 0 is the older entry), one pop port;
// head entry and valid come straight from flops.
module scalar_lsu_rsp_fifo
    import scalar_lsu_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push0_i,
    input  rsp_entry_t    entry0_i,
    input  logic          push1_i,
    input  rsp_entry_t    entry1_i,
    input  logic          pop_i,
    output logic          valid_o,
    output rsp_entry_t    entry_o,
    output logic [CW-1:0] count_o
);

    rsp_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr1_ptr;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok  = pop_i && (count_q != '0);
    assign wr1_ptr = push0_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    always_comb begin
        wr_ptr_d = push1_i ? ptr_inc(wr1_ptr) : wr1_ptr;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push0_i) mem_q[wr_ptr_q] <= entry0_i;
            if (push1_i) mem_q[wr1_ptr]  <= entry1_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign entry_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/scalar_lsu.sv
// Scalar load/store unit: issues one request per cycle to a 1-cycle-latency scalar memory and
// returns load results through a credit-managed response FIFO. Optional SCALAR_LSU_MISALIGN_EN traps misaligned accesses.
module scalar_lsu
    import scalar_lsu_pkg::*;
#(
    parameter int AWIDTH    = 13,
    parameter int RSP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_tag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_tag,
    output logic        rsp_err,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_we,
    output logic [3:0]  m_mask,
    output logic [31:0] m_addr,
    output logic [31:0] m_data,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    if (RSP_DEPTH < 2) begin : g_bad_depth
        $error("scalar_lsu: RSP_DEPTH must be at least 2");
    end
    if (AWIDTH < 1 || AWIDTH > 30) begin : g_bad_awidth
        $error("scalar_lsu: AWIDTH must be within 1..30");
    end

    lsu_size_e     size;
    logic [1:0]    offset;
    logic          misaligned, accept, load_issue, err_push, rsp_push;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   used;
    logic          inflight_q, inflight_d;
    pend_t         pend_q, pend_d;
    logic [7:0]    lane8;
    logic [15:0]   lane16;
    logic [31:0]   load_data;
    rsp_entry_t    load_entry, err_entry, head;
    logic          fifo_valid;

    assign size   = lsu_size_e'(req_size);
    assign offset = req_addr[1:0];

`ifdef SCALAR_LSU_MISALIGN_EN
    assign misaligned = ((size == SIZE_HALF) && offset[0]) ||
                        ((size == SIZE_WORD) && (offset != 2'b00)) ||
                        (size == SIZE_RSVD);
`else
    assign misaligned = 1'b0;
`endif

    // A credit covers both queued responses and the one load still waiting on memory.
    assign used       = {1'b0, fifo_count} + (CW+1)'(inflight_q);
    assign req_ready  = rst_n && m_ready && (used < (CW+1)'(RSP_DEPTH));
    assign accept     = req_valid && req_ready;
    assign load_issue = accept && !req_we && !misaligned;
    assign err_push   = accept && !req_we && misaligned;
    assign rsp_push   = inflight_q && m_rvalid;

    assign m_valid = accept && !misaligned;
    assign m_we    = req_we;
    assign m_addr  = {req_addr[31:2], 2'b00};
    assign m_mask  = lane_mask(size, offset);

    always_comb begin
        case (size)
            SIZE_BYTE: m_data = {4{req_wdata[7:0]}};
            SIZE_HALF: m_data = {2{req_wdata[15:0]}};
            default:   m_data = req_wdata;
        endcase
    end

    assign pend_d     = load_issue ? '{offset: offset, size: size, sext: req_signed, tag: req_tag} : pend_q;
    assign inflight_d = load_issue || (inflight_q && !m_rvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            pend_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        lane8  = m_rdata[{pend_q.offset, 3'b000} +: 8];
        lane16 = pend_q.offset[1] ? m_rdata[31:16] : m_rdata[15:0];
        case (pend_q.size)
            SIZE_BYTE: load_data = {{24{pend_q.sext & lane8[7]}}, lane8};
            SIZE_HALF: load_data = {{16{pend_q.sext & lane16[15]}}, lane16};
            default:   load_data = m_rdata;
        endcase
    end

    assign load_entry = '{data: load_data, tag: pend_q.tag, err: 1'b0};
    assign err_entry  = '{data: 32'd0, tag: req_tag, err: 1'b1};

    // The memory result belongs to an older request than a same-cycle trapped load, so it takes port 0.
    scalar_lsu_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push0_i  (rsp_push),
        .entry0_i (load_entry),
        .push1_i  (err_push),
        .entry1_i (err_entry),
        .pop_i    (rsp_valid && rsp_ready),
        .valid_o  (fifo_valid),
        .entry_o  (head),
        .count_o  (fifo_count)
    );

    assign rsp_valid = fifo_valid;
    assign rsp_data  = head.data;
    assign rsp_tag   = head.tag;
    assign rsp_err   = head.err;

endmodule

// File: tb/tb_scalar_lsu.sv
// Bench for scalar_lsu: directed vectors with hand-computed results, expected responses queued and
// checked by a separate response monitor. Define SCALAR_LSU_MISALIGN_EN to cover the trap build.
`timescale 1ns/1ps
module tb_scalar_lsu;
    import scalar_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        m_valid, m_ready, m_we, m_rvalid;
    logic [3:0]  m_mask;
    logic [31:0] m_addr, m_data, m_rdata;

    logic        memRvalid = 1'b0;
    logic        extraRvalid = 1'b0;
    logic [31:0] memRdata = 32'd0;

    int checks = 0;
    int failures = 0;

    logic [31:0] rdQ[$];
    rsp_entry_t  expQ[$];

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
        logic        expMValid;
        logic [3:0]  expMask;
        logic [31:0] expMAddr;
        logic [31:0] expMData;
        logic        scoreRsp;
        logic [31:0] memData;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    always #5 clk = ~clk;

    assign m_rvalid = memRvalid | extraRvalid;
    assign m_rdata  = memRdata;

    scalar_lsu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_we       (m_we),
        .m_mask     (m_mask),
        .m_addr     (m_addr),
        .m_data     (m_data),
        .m_rvalid   (m_rvalid),
        .m_rdata    (m_rdata)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: a read seen in one cycle returns its data one cycle later, in issue order.
    initial begin : memModel
        logic hit;
        forever begin
            @(negedge clk);
            hit = m_valid && !m_we;
            @(posedge clk);
            #1;
            memRvalid = hit;
            if (hit) begin
                checkOutput("memReadExpected", 32'(rdQ.size() != 0), 32'd1);
                memRdata = (rdQ.size() != 0) ? rdQ.pop_front() : 32'hDEAD_BEEF;
            end else begin
                memRdata = 32'hDEAD_BEEF;
            end
        end
    end

    always @(negedge clk) begin : monitor
        rsp_entry_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("rspData", rsp_data, e.data);
                checkOutput("rspTag", 32'(rsp_tag), 32'(e.tag));
                checkOutput("rspErr", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic applyStimulus(input vec_t v, input int maxWait, output bit accepted);
        accepted   = 1'b0;
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_tag    = v.tag;
        for (int i = 0; i < maxWait && !accepted; i++) begin
            @(negedge clk);
            if (req_ready) begin
                accepted = 1'b1;
                checkOutput({v.name, ".mValid"}, 32'(m_valid), 32'(v.expMValid));
                if (v.expMValid) begin
                    checkOutput({v.name, ".mWe"}, 32'(m_we), 32'(v.we));
                    checkOutput({v.name, ".mMask"}, 32'(m_mask), 32'(v.expMask));
                    checkOutput({v.name, ".mAddr"}, m_addr, v.expMAddr);
                    if (v.we) checkOutput({v.name, ".mData"}, m_data, v.expMData);
                    else rdQ.push_back(v.memData);
                end
                if (!v.we && v.scoreRsp) expQ.push_back('{data: v.expData, tag: v.tag, err: v.expErr});
            end
            @(posedge clk);
            #2;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput({name, ".drained"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        vec_t v;
        vec_t tbl[$];
        bit   acc;
        int   n;

        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'd0; req_tag = 5'd1; m_ready = 1'b1; rsp_ready = 1'b1;
        #12;
        checkOutput("reset.rspValid", 32'(rsp_valid), 32'd0);
        checkOutput("reset.rspData", rsp_data, 32'd0);
        checkOutput("reset.rspTag", 32'(rsp_tag), 32'd0);
        checkOutput("reset.rspErr", 32'(rsp_err), 32'd0);
        checkOutput("reset.reqReady", 32'(req_ready), 32'd0);
        checkOutput("reset.mValid", 32'(m_valid), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1; req_valid = 1'b0;
        @(posedge clk); #2;

        v = '{"storeByte", 1'b1, 2'd0, 1'b0, 32'h5, 32'hAB, 5'd0, 1'b1, 4'b0010, 32'h4, 32'hABABABAB,
              1'b0, 32'h0, 32'h0, 1'b0};
        applyStimulus(v, 5, acc);
        checkOutput("storeByte.accepted", 32'(acc), 32'd1);

        v = '{"loadHalfS", 1'b0, 2'd1, 1'b1, 32'h6, 32'h0, 5'd7, 1'b1, 4'b1100, 32'h4, 32'h0,
              1'b1, 32'h8001_0000, 32'hFFFF_8001, 1'b0};
        applyStimulus(v, 5, acc);
        checkOutput("loadHalfS.accepted", 32'(acc), 32'd1);
        @(negedge clk);
        checkOutput("loadHalfS.rspValidEarly", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("loadHalfS.rspValidOnTime", 32'(rsp_valid), 32'd1);
        drain("loadHalfS");

        tbl.push_back('{"loadByteU", 1'b0, 2'd0, 1'b0, 32'h3, 32'h0, 5'd3, 1'b1, 4'b1000, 32'h0, 32'h0,
                        1'b1, 32'hF000_0000, 32'h0000_00F0, 1'b0});
        tbl.push_back('{"loadByteS", 1'b0, 2'd0, 1'b1, 32'h1, 32'h0, 5'd9, 1'b1, 4'b0010, 32'h0, 32'h0,
                        1'b1, 32'h0000_8000, 32'hFFFF_FF80, 1'b0});
        tbl.push_back('{"loadHalfU", 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 5'h11, 1'b1, 4'b1100, 32'h0, 32'h0,
                        1'b1, 32'h8001_1234, 32'h0000_8001, 1'b0});
        tbl.push_back('{"loadWord", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 5'h1F, 1'b1, 4'b1111, 32'h8, 32'h0,
                        1'b1, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0});
        tbl.push_back('{"loadHalfPos", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 5'd4, 1'b1, 4'b0011, 32'h10, 32'h0,
                        1'b1, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0});
        tbl.push_back('{"storeHalf", 1'b1, 2'd1, 1'b0, 32'h2, 32'h1234_5678, 5'd0, 1'b1, 4'b1100, 32'h0,
                        32'h5678_5678, 1'b0, 32'h0, 32'h0, 1'b0});
        tbl.push_back('{"storeWord", 1'b1, 2'd2, 1'b0, 32'hC, 32'hDEAD_BEEF, 5'd0, 1'b1, 4'b1111, 32'hC,
                        32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 1'b0});
`ifdef SCALAR_LSU_MISALIGN_EN
        tbl.push_back('{"misalignWord", 1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 5'hA, 1'b0, 4'b0000, 32'h0, 32'h0,
                        1'b1, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{"misalignStore", 1'b1, 2'd2, 1'b0, 32'h31, 32'h5, 5'd0, 1'b0, 4'b0000, 32'h0, 32'h0,
                        1'b0, 32'h0, 32'h0, 1'b0});
`else
        tbl.push_back('{"misalignWord", 1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 5'hA, 1'b1, 4'b1111, 32'h0, 32'h0,
                        1'b1, 32'h1122_3344, 32'h1122_3344, 1'b0});
        tbl.push_back('{"oddHalf", 1'b0, 2'd1, 1'b0, 32'h7, 32'h0, 5'hB, 1'b1, 4'b1100, 32'h4, 32'h0,
                        1'b1, 32'hABCD_0000, 32'h0000_ABCD, 1'b0});
        tbl.push_back('{"rsvdSize", 1'b0, 2'd3, 1'b1, 32'h20, 32'h0, 5'hC, 1'b1, 4'b1111, 32'h20, 32'h0,
                        1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0});
`endif
        foreach (tbl[i]) begin
            applyStimulus(tbl[i], 10, acc);
            checkOutput({tbl[i].name, ".accepted"}, 32'(acc), 32'd1);
        end
        drain("table");

        rsp_ready = 1'b0;
        v = '{"bp1", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd1, 1'b1, 4'b1111, 32'h40, 32'h0,
              1'b1, 32'h1111_0001, 32'h1111_0001, 1'b0};
        applyStimulus(v, 1, acc);
        checkOutput("bp1.accepted", 32'(acc), 32'd1);
        v = '{"bp2", 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 5'd2, 1'b1, 4'b1111, 32'h44, 32'h0,
              1'b1, 32'h2222_0002, 32'h2222_0002, 1'b0};
        applyStimulus(v, 1, acc);
        checkOutput("bp2.accepted", 32'(acc), 32'd1);
        v = '{"bp3", 1'b0, 2'd2, 1'b0, 32'h48, 32'h0, 5'd3, 1'b1, 4'b1111, 32'h48, 32'h0,
              1'b1, 32'h3333_0003, 32'h3333_0003, 1'b0};
        applyStimulus(v, 1, acc);
        checkOutput("bp3.rejected", 32'(acc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp.reqReadyHeld", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 5);
        checkOutput("bp.reqReadyAfterPop", 32'(req_ready), 32'd1);
        @(posedge clk); #2;
        applyStimulus(v, 10, acc);
        checkOutput("bp3.retryAccepted", 32'(acc), 32'd1);
        drain("backpressure");

        v = '{"rstLoad", 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 5'd5, 1'b1, 4'b1111, 32'h80, 32'h0,
              1'b0, 32'h5555_5555, 32'h0, 1'b0};
        applyStimulus(v, 5, acc);
        checkOutput("rstLoad.accepted", 32'(acc), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rstLoad.reqReadyInReset", 32'(req_ready), 32'd0);
        checkOutput("rstLoad.rspValidInReset", 32'(rsp_valid), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        extraRvalid = 1'b1;
        @(posedge clk); #2;
        extraRvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rstLoad.noRsp", 32'(rsp_valid), 32'd0);
        end
        checkOutput("rstLoad.reqReadyBack", 32'(req_ready), 32'd1);

        @(posedge clk); #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
